// File: rtl/mult32x32_pkg.sv
// Shared types and constants for the 32x32 multiplier operand feeder.
// MULT_FEED_TIMEOUT_EN (optional) enables the feeder's multiplication watchdog.
package mult32x32_pkg;

    localparam int unsigned OPER_W = 32;
    localparam int unsigned PROD_W = 64;

    // Product reported when the watchdog gives up on a multiplication.
    localparam logic [PROD_W-1:0] TIMEOUT_PRODUCT = {PROD_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        OUTPUT
    } feeder_state_t;

endpackage

// File: rtl/mult32x32_op_fifo.sv
// Synchronous FIFO holding {a, b} operand pairs for the multiplier feeder.
// Head entry is presented combinationally; pointers wrap naturally (DEPTH is a power of 2).
module mult32x32_op_fifo
    import mult32x32_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2 * OPER_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign push_en = push && (count < (PTR_W + 1)'(DEPTH));
    assign pop_en  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_en && !pop_en) begin
                count <= count + 1'b1;
            end else if (pop_en && !push_en) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult32x32_feeder.sv
// Operand-issue stage for the 32x32 multiplier: buffers pairs, sequences start/busy, holds result.
// Defining MULT_FEED_TIMEOUT_EN adds a watchdog that aborts a multiplication after MAX_LAT cycles.
module mult32x32_feeder
    import mult32x32_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_LAT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPER_W-1:0]      in_a,
    input  logic [OPER_W-1:0]      in_b,
    output logic                   m_start,
    output logic [OPER_W-1:0]      m_a,
    output logic [OPER_W-1:0]      m_b,
    input  logic                   m_busy,
    input  logic [PROD_W-1:0]      m_product,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PROD_W-1:0]      out_product,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   timeout_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_LAT < 1) begin : g_param_check
        $error("mult32x32_feeder: DEPTH must be a power of 2 >= 2 and MAX_LAT >= 1");
    end

    feeder_state_t         state;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [2*OPER_W-1:0]   fifo_head;
    logic                  wd_fire;

    // in_ready depends on the count only, so a same-cycle pop never admits a push into a full FIFO.
    assign in_ready  = occupancy < CNT_W'(DEPTH);
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state == IDLE) && (occupancy != '0);

    mult32x32_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * OPER_W)
    ) u_op_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({in_a, in_b}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (occupancy)
    );

`ifdef MULT_FEED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(MAX_LAT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign wd_fire     = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                         (wd_cnt == WD_W'(MAX_LAT - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (fifo_pop) begin
                wd_cnt <= '0;
            end else if ((state == WAIT_BUSY) || (state == WAIT_DONE)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            m_start     <= 1'b0;
            m_a         <= '0;
            m_b         <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        m_a     <= fifo_head[2*OPER_W-1:OPER_W];
                        m_b     <= fifo_head[OPER_W-1:0];
                        m_start <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start <= 1'b0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (wd_fire) begin
                        out_product <= TIMEOUT_PRODUCT;
                        out_valid   <= 1'b1;
                        state       <= OUTPUT;
                    end else if (m_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (wd_fire) begin
                        out_product <= TIMEOUT_PRODUCT;
                        out_valid   <= 1'b1;
                        state       <= OUTPUT;
                    end else if (!m_busy) begin
                        out_product <= m_product;
                        out_valid   <= 1'b1;
                        state       <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult32x32_feeder.sv
// Directed bench for mult32x32_feeder with a fixed-latency multiplier model.
// The watchdog scenario runs only when MULT_FEED_TIMEOUT_EN is defined.
module tb_mult32x32_feeder;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_LAT  = 16;
    localparam int unsigned BUSY_CYC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        m_start;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        m_busy;
    logic [63:0] m_product;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_product;
    logic [2:0]  occupancy;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    mult32x32_feeder #(
        .DEPTH   (DEPTH),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .m_start     (m_start),
        .m_a         (m_a),
        .m_b         (m_b),
        .m_busy      (m_busy),
        .m_product   (m_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .occupancy   (occupancy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Multiplier model: busy for BUSY_CYC cycles after a start; 'stuck' pins busy high.
    logic        busy_q;
    int unsigned mcnt;
    logic [63:0] mprod;
    logic        stuck = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            mcnt   <= 0;
            mprod  <= '0;
        end else if (m_start && !busy_q) begin
            busy_q <= 1'b1;
            mcnt   <= BUSY_CYC;
            mprod  <= 64'(m_a) * 64'(m_b);
        end else if (busy_q) begin
            if (mcnt <= 1) begin
                busy_q <= 1'b0;
                mcnt   <= 0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    assign m_busy    = busy_q | stuck;
    assign m_product = mprod;

    // Start-pulse monitor, sampled at the active edge.
    int start_cnt  = 0;
    int cyc        = 0;
    int last_start = -1;
    int min_gap    = 1000000;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_start) begin
            start_cnt <= start_cnt + 1;
            if (last_start >= 0 && (cyc - last_start) < min_gap) begin
                min_gap <= cyc - last_start;
            end
            last_start <= cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed simulation still running, expected finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; waits (bounded) for in_ready before pushing.
    task automatic push(input logic [31:0] a, input logic [31:0] b, output int waits);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        waits    = 0;
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) chk("push_accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; optionally checks it rose one edge after busy fell.
    task automatic get_result(input bit chk_lat, output logic [63:0] p);
        logic b1, b2;
        int   n;
        b1 = 1'b0;
        b2 = 1'b0;
        n  = 0;
        while (!out_valid && n < 100) begin
            b2 = b1;
            b1 = m_busy;
            @(negedge clk);
            n++;
        end
        chk("result_arrives", 64'(out_valid), 64'd1);
        if (chk_lat) chk("valid_after_busy_drop", 64'({b2, b1}), 64'b10);
        p = out_product;
    endtask

    logic [63:0] p;
    logic [63:0] p0;
    int          w;
    int          s0;
    bit          bad;
    bit          bad2;
    logic [63:0] exp3 [6];

    initial begin
        exp3[0] = 64'h0000_0000_0000_0001;
        exp3[1] = 64'h0000_0000_0000_0006;
        exp3[2] = 64'h0000_0000_0000_0100;
        exp3[3] = 64'h0000_0000_1234_0000;
        exp3[4] = 64'h0000_0001_0000_0000;
        exp3[5] = 64'h0000_0001_FFFF_FFFE;

        // Reset state while held in reset.
        repeat (2) @(negedge clk);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_m_start", 64'(m_start), 64'd0);
        chk("rst_m_ab", {m_a, m_b}, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_product", out_product, 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single pair 3*5 with start timing and output hold.
        push(32'h3, 32'h5, w);
        chk("t1_occ_after_push", 64'(occupancy), 64'd1);
        chk("t1_no_start_yet", 64'(m_start), 64'd0);
        @(negedge clk);
        chk("t1_start_pulse", 64'(m_start), 64'd1);
        chk("t1_m_ab", {m_a, m_b}, {32'h3, 32'h5});
        chk("t1_occ_after_pop", 64'(occupancy), 64'd0);
        @(negedge clk);
        chk("t1_start_one_cycle", 64'(m_start), 64'd0);
        get_result(1'b1, p);
        chk("t1_product", p, 64'hF);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!out_valid || out_product !== 64'hF) bad = 1'b1;
        end
        chk("t1_hold_until_ready", 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t1_valid_cleared", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        chk("t1_start_count", 64'(start_cnt), 64'd1);

        // Full-scale operands.
        out_ready = 1'b1;
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        get_result(1'b1, p);
        chk("t2_product", p, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);

        // Back-to-back pushes: FIFO fills, sixth push stalls, results stay in order.
        min_gap = 1000000;
        fork
            begin
                int wt;
                push(32'h1, 32'h1, wt);
                push(32'h2, 32'h3, wt);
                chk("t3_push_pop_same_cycle", 64'(occupancy), 64'd1);
                push(32'h10, 32'h10, wt);
                push(32'h1234, 32'h1_0000, wt);
                push(32'h8000_0000, 32'h2, wt);
                chk("t3_full_occ", 64'(occupancy), 64'd4);
                chk("t3_full_not_ready", 64'(in_ready), 64'd0);
                push(32'hFFFF_FFFF, 32'h2, wt);
                chk("t3_push6_stalled", 64'(wt > 0), 64'd1);
            end
            begin
                logic [63:0] r;
                for (int i = 0; i < 6; i++) begin
                    get_result(1'b1, r);
                    chk($sformatf("t3_result%0d", i), r, exp3[i]);
                    @(negedge clk);
                end
            end
        join
        chk("t3_start_gap", 64'(min_gap > int'(BUSY_CYC)), 64'd1);

        // Consumer stalls for 20 cycles with three pairs queued.
        out_ready = 1'b0;
        push(32'h7, 32'h6, w);
        push(32'h100, 32'h100, w);
        push(32'hABCD, 32'h2, w);
        push(32'h1_0000, 32'h1_0000, w);
        get_result(1'b1, p0);
        chk("t4_first_product", p0, 64'h2A);
        s0  = start_cnt;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_product !== p0 || occupancy !== 3'd3) bad = 1'b1;
        end
        chk("t4_stable_during_stall", 64'(bad), 64'd0);
        chk("t4_no_start_while_valid", 64'(start_cnt), 64'(s0));
        chk("t4_occ_held", 64'(occupancy), 64'd3);
        out_ready = 1'b1;
        @(negedge clk);
        get_result(1'b1, p);
        chk("t4_result1", p, 64'h1_0000);
        @(negedge clk);
        get_result(1'b1, p);
        chk("t4_result2", p, 64'h1_579A);
        @(negedge clk);
        get_result(1'b1, p);
        chk("t4_result3", p, 64'h1_0000_0000);
        @(negedge clk);

        // Reset while waiting for the multiplier with two pairs buffered.
        push(32'h11, 32'h11, w);
        push(32'h22, 32'h22, w);
        push(32'h33, 32'h33, w);
        w = 0;
        while (!m_busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("t5_busy_seen", 64'(m_busy), 64'd1);
        repeat (2) @(negedge clk);
        chk("t5_occ_before_reset", 64'(occupancy), 64'd2);
        reset = 1'b0;
        #1;
        chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_occupancy", 64'(occupancy), 64'd0);
        chk("t5_rst_m_start", 64'(m_start), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        s0   = start_cnt;
        bad  = 1'b0;
        bad2 = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
            if (!in_ready) bad2 = 1'b1;
        end
        chk("t5_no_stale_result", 64'(bad), 64'd0);
        chk("t5_no_start_after_reset", 64'(start_cnt), 64'(s0));
        chk("t5_in_ready_after_release", 64'(bad2), 64'd0);

`ifdef MULT_FEED_TIMEOUT_EN
        // Multiplier hangs; watchdog reports all-ones, then normal operation resumes.
        stuck = 1'b1;
        push(32'h5, 32'h5, w);
        get_result(1'b0, p);
        chk("t6_timeout_err", 64'(timeout_err), 64'd1);
        chk("t6_timeout_product", p, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        stuck = 1'b0;
        @(negedge clk);
        push(32'h6, 32'h7, w);
        get_result(1'b1, p);
        chk("t6_recovered_product", p, 64'h2A);
        chk("t6_timeout_sticky", 64'(timeout_err), 64'd1);
        @(negedge clk);
`else
        chk("t6_timeout_tied_low", 64'(timeout_err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
